// File: rtl/tea_pkg.sv
// Shared constants, state type and round mixing function for the iterative TEA engine.
package tea_pkg;

  localparam logic [31:0] DELTA            = 32'h9e37_79b9;
  localparam logic [31:0] DECRYPT_SUM_0    = 32'hc6ef_3720;
  localparam logic [63:0] PDF_PLAIN_HEADER = 64'h2550_4446_2D31_2E36;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tea_state_e;

  // TEA Feistel function: ((v<<4)+ka) ^ (v+s) ^ ((v>>5)+kb), all modulo 2^32.
  function automatic logic [31:0] tea_mix(input logic [31:0] v, input logic [31:0] s,
                                          input logic [31:0] ka, input logic [31:0] kb);
    return ((v << 4) + ka) ^ (v + s) ^ ((v >> 5) + kb);
  endfunction

  function automatic logic [31:0] decrypt_start_sum(input int unsigned rounds);
    return DELTA * rounds;
  endfunction

endpackage

// File: rtl/tea_round_comb.sv
// Combinational single TEA round, encrypt or decrypt, including the running sum update.
module tea_round_comb
  import tea_pkg::*;
(
  input  logic [31:0]  v0_i,
  input  logic [31:0]  v1_i,
  input  logic [31:0]  sum_i,
  input  logic [127:0] key_i,
  input  logic         encrypt_i,
  output logic [31:0]  v0_o,
  output logic [31:0]  v1_o,
  output logic [31:0]  sum_o
);

  logic [31:0] k0_s, k1_s, k2_s, k3_s;
  logic [31:0] enc_sum_s, enc_v0_s, enc_v1_s;
  logic [31:0] dec_sum_s, dec_v0_s, dec_v1_s;

  assign k0_s = key_i[127:96];
  assign k1_s = key_i[95:64];
  assign k2_s = key_i[63:32];
  assign k3_s = key_i[31:0];

  // Encrypt adds DELTA before the round; decrypt uses the current sum and subtracts after.
  assign enc_sum_s = sum_i + DELTA;
  assign enc_v0_s  = v0_i + tea_mix(v1_i, enc_sum_s, k0_s, k1_s);
  assign enc_v1_s  = v1_i + tea_mix(enc_v0_s, enc_sum_s, k2_s, k3_s);

  assign dec_v1_s  = v1_i - tea_mix(v0_i, sum_i, k2_s, k3_s);
  assign dec_v0_s  = v0_i - tea_mix(dec_v1_s, sum_i, k0_s, k1_s);
  assign dec_sum_s = sum_i - DELTA;

  // Direction select.
  always_comb begin
    v0_o  = dec_v0_s;
    v1_o  = dec_v1_s;
    sum_o = dec_sum_s;
    if (encrypt_i) begin
      v0_o  = enc_v0_s;
      v1_o  = enc_v1_s;
      sum_o = enc_sum_s;
    end else begin
      v0_o  = dec_v0_s;
      v1_o  = dec_v1_s;
      sum_o = dec_sum_s;
    end
  end

endmodule

// File: rtl/tea_iter_engine.sv
// Iterative TEA engine: one round per enabled clock, valid/ready in and out.
// Optional header comparator flag built only when TEA_HDR_MATCH_EN is defined.
module tea_iter_engine
  import tea_pkg::*;
#(
  parameter int unsigned ROUNDS = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         encrypt,
  input  logic [63:0]  in_block,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  out_block,
  output logic         hdr_match
);

  localparam logic [31:0] DEC_SUM_START = decrypt_start_sum(ROUNDS);
  localparam logic [5:0]  LAST_CNT      = 6'(ROUNDS - 1);

  tea_state_e   state_q, state_d;
  logic [31:0]  v0_q, v0_d, v1_q, v1_d, sum_q, sum_d;
  logic [127:0] key_q, key_d;
  logic         enc_q, enc_d;
  logic [5:0]   cnt_q, cnt_d;
  logic         out_valid_q, out_valid_d;
  logic [63:0]  out_block_q, out_block_d;
  logic [31:0]  r_v0_s, r_v1_s, r_sum_s;
  logic         last_round_s, retire_s;

  tea_round_comb u_round (
    .v0_i      (v0_q),
    .v1_i      (v1_q),
    .sum_i     (sum_q),
    .key_i     (key_q),
    .encrypt_i (enc_q),
    .v0_o      (r_v0_s),
    .v1_o      (r_v1_s),
    .sum_o     (r_sum_s)
  );

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = out_valid_q;
  assign out_block    = out_block_q;
  assign last_round_s = (state_q == RUN) && (cnt_q == LAST_CNT);
  assign retire_s     = (state_q == DONE) && out_ready;

  // Next-state and datapath update; registers hold unless the FSM says otherwise.
  always_comb begin
    state_d     = state_q;
    v0_d        = v0_q;
    v1_d        = v1_q;
    sum_d       = sum_q;
    key_d       = key_q;
    enc_d       = enc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_block_d = out_block_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          v0_d    = in_block[31:0];
          v1_d    = in_block[63:32];
          key_d   = key;
          enc_d   = encrypt;
          sum_d   = encrypt ? 32'h0000_0000 : DEC_SUM_START;
          cnt_d   = 6'd0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        v0_d  = r_v0_s;
        v1_d  = r_v1_s;
        sum_d = r_sum_s;
        cnt_d = cnt_q + 6'd1;
        if (last_round_s) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          out_block_d = {r_v1_s, r_v0_s};
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers, frozen while ena is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      v0_q        <= 32'h0000_0000;
      v1_q        <= 32'h0000_0000;
      sum_q       <= 32'h0000_0000;
      key_q       <= 128'h0;
      enc_q       <= 1'b0;
      cnt_q       <= 6'd0;
      out_valid_q <= 1'b0;
      out_block_q <= 64'h0;
    end else if (ena) begin
      state_q     <= state_d;
      v0_q        <= v0_d;
      v1_q        <= v1_d;
      sum_q       <= sum_d;
      key_q       <= key_d;
      enc_q       <= enc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_block_q <= out_block_d;
    end
  end

`ifdef TEA_HDR_MATCH_EN
  logic hdr_match_q;

  // Header flag loads alongside out_block on entry to DONE and clears on retire.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hdr_match_q <= 1'b0;
    end else if (ena) begin
      if (last_round_s) begin
        hdr_match_q <= ({r_v1_s, r_v0_s} == PDF_PLAIN_HEADER);
      end else if (retire_s) begin
        hdr_match_q <= 1'b0;
      end
    end
  end

  assign hdr_match = hdr_match_q;
`else
  assign hdr_match = 1'b0;
`endif

endmodule

// File: tb/tb_tea_iter_engine.sv
// Self-checking bench for tea_iter_engine against a loop-form TEA reference model.
module tb_tea_iter_engine;

  localparam int          ROUNDS = 32;
  localparam logic [31:0] DELTA  = 32'h9e3779b9;
  localparam logic [63:0] HDR    = 64'h2550_4446_2D31_2E36;
  localparam logic [127:0] HKEY  = 128'h48756c6b_20697320_7468616c_616d6963;
  localparam logic [63:0] V1_CT  = {32'h94baa940, 32'h41ea3a0a};

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         ena = 1'b1;
  logic         in_valid = 1'b0;
  logic         encrypt = 1'b1;
  logic [63:0]  in_block = 64'h0;
  logic [127:0] key = 128'h0;
  logic         out_ready = 1'b0;
  logic         in_ready, out_valid, hdr_match;
  logic [63:0]  out_block;

  int n_checks = 0;
  int n_fail   = 0;

  tea_iter_engine #(.ROUNDS(ROUNDS)) dut (
    .clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid), .in_ready(in_ready),
    .encrypt(encrypt), .in_block(in_block), .key(key), .out_valid(out_valid),
    .out_ready(out_ready), .out_block(out_block), .hdr_match(hdr_match)
  );

  always #5 clk = ~clk;

  // Textbook TEA, written as the usual y/z/sum loop.
  function automatic logic [63:0] tea_ref(input logic [63:0] blk, input logic [127:0] k, input bit enc);
    logic [31:0] y, z, s, a, b, c, d;
    y = blk[31:0]; z = blk[63:32];
    a = k[127:96]; b = k[95:64]; c = k[63:32]; d = k[31:0];
    if (enc) begin
      s = 32'h0;
      for (int i = 0; i < ROUNDS; i++) begin
        s = s + DELTA;
        y = y + (((z << 4) + a) ^ (z + s) ^ ((z >> 5) + b));
        z = z + (((y << 4) + c) ^ (y + s) ^ ((y >> 5) + d));
      end
    end else begin
      s = DELTA * ROUNDS;
      for (int i = 0; i < ROUNDS; i++) begin
        z = z - (((y << 4) + c) ^ (y + s) ^ ((y >> 5) + d));
        y = y - (((z << 4) + a) ^ (z + s) ^ ((z >> 5) + b));
        s = s - DELTA;
      end
    end
    return {z, y};
  endfunction

  function automatic bit hdr_expect(input logic [63:0] blk);
`ifdef TEA_HDR_MATCH_EN
    return blk == HDR;
`else
    return 1'b0;
`endif
  endfunction

  task automatic accept(input logic [63:0] b, input logic [127:0] k, input bit e);
    in_block = b; key = k; encrypt = e; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_block = {$urandom, $urandom};
    key = {$urandom, $urandom, $urandom, $urandom};
    encrypt = ~e;
  endtask

  // Counts edges since accept until out_valid, checking in_ready stays low meanwhile.
  task automatic wait_done(output int cyc, output bit rdy_ok);
    cyc = 0; rdy_ok = 1'b1;
    while (out_valid !== 1'b1 && cyc < 200) begin
      if (in_ready !== 1'b0) rdy_ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic retire(input logic [63:0] exp_blk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_block !== exp_blk || hdr_match !== 1'b0) begin
      n_fail++;
      $display("FAIL retire: valid=%b ready=%b blk=%h hdr=%b, want 0 1 %h 0",
               out_valid, in_ready, out_block, hdr_match, exp_blk);
    end
  endtask

  task automatic run_one(input string nm, input logic [63:0] b, input logic [127:0] k, input bit e,
                         input logic [63:0] exp_blk, input int exp_lat);
    int cyc; bit rdy_ok;
    accept(b, k, e);
    wait_done(cyc, rdy_ok);
    n_checks++;
    if (cyc !== exp_lat || out_block !== exp_blk || rdy_ok !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: lat=%0d blk=%h ready_low=%b ready=%b, want lat=%0d blk=%h 1 0",
               nm, cyc, out_block, rdy_ok, in_ready, exp_lat, exp_blk);
    end
    n_checks++;
    if (hdr_match !== hdr_expect(exp_blk)) begin
      n_fail++;
      $display("FAIL %s_hdr: hdr_match=%b want %b", nm, hdr_match, hdr_expect(exp_blk));
    end
    retire(exp_blk);
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_block !== 64'h0 || hdr_match !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: ready=%b valid=%b blk=%h hdr=%b, want 1 0 0 0",
               in_ready, out_valid, out_block, hdr_match);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_known_vector();
    n_checks++;
    if (tea_ref(64'h0, 128'h0, 1'b1) !== V1_CT) begin
      n_fail++;
      $display("FAIL ref_model: got %h want %h", tea_ref(64'h0, 128'h0, 1'b1), V1_CT);
    end
    run_one("encrypt_zero", 64'h0, 128'h0, 1'b1, V1_CT, ROUNDS);
  endtask

  task automatic test_decrypt();
    run_one("decrypt_zero", V1_CT, 128'h0, 1'b0, 64'h0, ROUNDS);
  endtask

  task automatic test_round_trip();
    logic [63:0] ct;
    ct = tea_ref(HDR, HKEY, 1'b1);
    run_one("hdr_encrypt", HDR, HKEY, 1'b1, ct, ROUNDS);
    run_one("hdr_decrypt", ct, HKEY, 1'b0, HDR, ROUNDS);
  endtask

  task automatic test_done_hold();
    int cyc; bit rdy_ok; bit stable;
    logic [63:0] b, exp_blk;
    b = {$urandom, $urandom};
    exp_blk = tea_ref(b, HKEY, 1'b1);
    accept(b, HKEY, 1'b1);
    wait_done(cyc, rdy_ok);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_block = {$urandom, $urandom};
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || out_block !== exp_blk || in_ready !== 1'b0) stable = 1'b0;
    end
    in_valid = 1'b0;
    n_checks++;
    if (stable !== 1'b1 || cyc !== ROUNDS) begin
      n_fail++;
      $display("FAIL done_hold: stable=%b lat=%0d blk=%h, want 1 %0d %h", stable, cyc, out_block, ROUNDS, exp_blk);
    end
    retire(exp_blk);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ignored_input: ready=%b valid=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_ena_stall();
    int cyc;
    accept(64'h0, 128'h0, 1'b1);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 200) begin
      ena = (cyc >= 10 && cyc < 15) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    ena = 1'b1;
    n_checks++;
    if (cyc !== ROUNDS + 5 || out_block !== V1_CT) begin
      n_fail++;
      $display("FAIL ena_stall: lat=%0d blk=%h, want %0d %h", cyc, out_block, ROUNDS + 5, V1_CT);
    end
    retire(V1_CT);
  endtask

  task automatic test_reset_midrun();
    accept(HDR, HKEY, 1'b1);
    repeat (16) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_block !== 64'h0 || hdr_match !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midrun: ready=%b valid=%b blk=%h hdr=%b, want 1 0 0 0",
               in_ready, out_valid, out_block, hdr_match);
    end
    rst = 1'b1;
    run_one("after_reset", 64'h0, 128'h0, 1'b1, V1_CT, ROUNDS);
  endtask

  task automatic test_random();
    logic [63:0] b; logic [127:0] k; bit e;
    for (int i = 0; i < 8; i++) begin
      b = {$urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom};
      e = 1'($urandom_range(0, 1));
      run_one("random", b, k, e, tea_ref(b, k, e), ROUNDS);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp_q[$];
    int t_out[$];
    int cyc; bit took; bit vals_ok;
    logic [63:0] e_blk;
    vals_ok = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    encrypt = 1'b1;
    key = HKEY;
    in_block = {$urandom, $urandom};
    cyc = 0;
    while (t_out.size() < 3 && cyc < 400) begin
      took = (in_ready === 1'b1);
      if (took) exp_q.push_back(tea_ref(in_block, key, 1'b1));
      @(posedge clk); #1;
      cyc++;
      if (took) in_block = {$urandom, $urandom};
      if (out_valid === 1'b1) begin
        t_out.push_back(cyc);
        e_blk = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
        if (out_block !== e_blk) vals_ok = 1'b0;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_checks++;
    if (t_out.size() !== 3 || vals_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL back_to_back_data: results=%0d values_ok=%b, want 3 1", t_out.size(), vals_ok);
    end else begin
      n_checks++;
      if (t_out[1] - t_out[0] !== ROUNDS + 2 || t_out[2] - t_out[1] !== ROUNDS + 2) begin
        n_fail++;
        $display("FAIL back_to_back_rate: intervals=%0d,%0d want %0d",
                 t_out[1] - t_out[0], t_out[2] - t_out[1], ROUNDS + 2);
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_known_vector();
    test_decrypt();
    test_round_trip();
    test_done_hold();
    test_ena_stall();
    test_reset_midrun();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
